dac_spi_tx: RTL and testbench

SPI shift engine for the sensor-bias DAC, clocked by the `dac_clk` output of the MMCM. It accepts one configuration word per valid/ready handshake from the DAC configuration sequencer and serialises it MSB-first onto the DAC pins `dac_sck_o`, `dac_cs_n_o` and `dac_mosi_o`. It enforces programmable chip-select setup, hold and inter-frame gap times, and returns a one-cycle completion pulse so the sequencer can step to the next word.

---
 rtl/dac_spi_tx.sv | 147 ++++++++++++++
 tb/tb_dac_spi_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for the sensor-bias DAC: one word per valid/ready
// handshake, MSB first, with programmable chip-select setup, hold and gap times.
module dac_spi_tx #(
  parameter int WORD_W   = 24,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic              dac_clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dac_sck_o,
  output logic              dac_cs_n_o,
  output logic              dac_mosi_o
);

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int BIT_W  = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               phase_q, phase_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic               sck_q, sck_d;
  logic               cs_n_q, cs_n_d;
  logic               mosi_q, mosi_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Outputs are derived from the next state so every pin comes straight off a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    shreg_d   = shreg_q;
    case (state_q)
      IDLE: begin
        if (word_valid_i && ready_q) begin
          state_d   = SETUP;
          shreg_d   = word_i;
          cnt_d     = '0;
          bit_cnt_d = BIT_W'(WORD_W);
          phase_d   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_cnt_q == BIT_W'(1)) begin
            state_d = HOLD;
            phase_d = 1'b0;
          end else begin
            // New low phase: advance to the next bit while SCK is low.
            phase_d   = 1'b0;
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            shreg_d   = shreg_q << 1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(CS_GAP - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cs_n_d  = !(state_d inside {SETUP, SHIFT, HOLD});
    sck_d   = (state_d == SHIFT) && phase_d;
    mosi_d  = cs_n_d ? 1'b0 : shreg_d[WORD_W-1];
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == HOLD) && (state_d == GAP);
  end

  always_ff @(posedge dac_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      shreg_q   <= '0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      shreg_q   <= shreg_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign word_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign dac_sck_o    = sck_q;
  assign dac_cs_n_o   = cs_n_q;
  assign dac_mosi_o   = mosi_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: a default-parameter instance driven from a
// vector table plus hand sequences, and a minimal-timing instance for the sweep.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [23:0] word  = '0;
  logic        valid = 1'b0;
  logic        ready, busy, done, sck, cs_n, mosi;

  logic [7:0]  s_word  = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, s_busy, s_done, s_sck, s_cs_n, s_mosi;

  dac_spi_tx dut (
    .dac_clk(clk), .rst_n(rst_n), .word_i(word), .word_valid_i(valid),
    .word_ready_o(ready), .busy_o(busy), .done_o(done),
    .dac_sck_o(sck), .dac_cs_n_o(cs_n), .dac_mosi_o(mosi)
  );

  dac_spi_tx #(.WORD_W(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut_s (
    .dac_clk(clk), .rst_n(rst_n), .word_i(s_word), .word_valid_i(s_valid),
    .word_ready_o(s_ready), .busy_o(s_busy), .done_o(s_done),
    .dac_sck_o(s_sck), .dac_cs_n_o(s_cs_n), .dac_mosi_o(s_mosi)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Bus monitor for the default instance; only this process writes these.
  int          cyc = 0, rises = 0, cs_low = 0, fall_cyc = 0, first_rise_delay = 0;
  int          busy_cnt = 0, done_cnt = 0, gap_cnt = 0, frames = 0, viol = 0;
  int          busy_rises = 0, busy_rise_cyc = 0, prev_busy_rise_cyc = 0;
  int          last_rises = 0, last_cs_low = 0;
  logic [31:0] rx = '0, last_bits = '0;
  logic        prev_cs_n = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_cs_n = 1'b1;
      prev_sck  = 1'b0;
      prev_mosi = 1'b0;
      prev_busy = 1'b0;
    end else begin
      cyc++;
      if (!cs_n && prev_cs_n) begin
        rx = '0; rises = 0; cs_low = 0; fall_cyc = cyc;
      end
      if (!cs_n) cs_low++;
      if (!cs_n && sck && !prev_sck) begin
        if (rises == 0) first_rise_delay = cyc - fall_cyc;
        rx = {rx[30:0], mosi};
        rises++;
      end
      if (sck && prev_sck && (mosi != prev_mosi)) viol++;
      if (cs_n && !prev_cs_n) begin
        frames++; last_bits = rx; last_rises = rises; last_cs_low = cs_low;
      end
      if (busy && !prev_busy) begin
        busy_rises++; prev_busy_rise_cyc = busy_rise_cyc; busy_rise_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (busy && cs_n) gap_cnt++;
      prev_cs_n = cs_n; prev_sck = sck; prev_mosi = mosi; prev_busy = busy;
    end
  end

  // Monitor for the minimal-timing instance.
  int         s_rises = 0, s_high = 0, s_toggles = 0, s_busy_cnt = 0, s_done_cnt = 0;
  logic [7:0] s_rx = '0;
  logic       s_prev_sck = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (!s_cs_n && s_sck && !s_prev_sck) begin
        s_rx = {s_rx[6:0], s_mosi};
        s_rises++;
      end
      if (!s_cs_n && s_sck) s_high++;
      if (!s_cs_n && (s_sck != s_prev_sck)) s_toggles++;
      if (s_busy) s_busy_cnt++;
      if (s_done) s_done_cnt++;
      s_prev_sck = s_sck;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_busy(input logic level, input int max_cyc, output logic tmo);
    tmo = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (busy == level) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [23:0] word;
    logic        corrupt;
    logic [23:0] exp_bits;
  } vec_t;

  vec_t vecs[3];

  task automatic apply_stimulus(input vec_t v, input int idx);
    int   b0, d0, v0;
    logic tmo;
    @(negedge clk); #1;
    b0 = busy_cnt; d0 = done_cnt; v0 = viol;
    word  = v.word;
    valid = 1'b1;
    wait_busy(1'b1, 20, tmo);
    valid = 1'b0;
    check_output($sformatf("vec%0d_accept_timeout", idx), {31'd0, tmo}, 32'd0);
    check_output($sformatf("vec%0d_accept_pins", idx), {29'd0, cs_n, ready, mosi},
                 {29'd0, 1'b0, 1'b0, v.exp_bits[23]});
    if (v.corrupt) begin
      repeat (40) @(negedge clk);
      #1 word = 24'hFFFFFF;
    end
    wait_busy(1'b0, 400, tmo);
    check_output($sformatf("vec%0d_end_timeout", idx), {31'd0, tmo}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_output($sformatf("vec%0d_bits", idx), last_bits, {8'd0, v.exp_bits});
    check_output($sformatf("vec%0d_rises", idx), last_rises, 32'd24);
    check_output($sformatf("vec%0d_cs_low", idx), last_cs_low, 32'd196);
    check_output($sformatf("vec%0d_busy", idx), busy_cnt - b0, 32'd200);
    check_output($sformatf("vec%0d_done", idx), done_cnt - d0, 32'd1);
    check_output($sformatf("vec%0d_first_rise", idx), first_rise_delay, 32'd6);
    check_output($sformatf("vec%0d_mosi_stable", idx), viol - v0, 32'd0);
  endtask

  initial begin
    int   g0, d0, f0, bad;
    logic tmo;
    logic [1:0] pre;

    vecs[0] = '{24'hA53C0F, 1'b0, 24'b1010_0101_0011_1100_0000_1111};
    vecs[1] = '{24'h123456, 1'b1, 24'b0001_0010_0011_0100_0101_0110};
    vecs[2] = '{24'hC35A96, 1'b0, 24'b1100_0011_0101_1010_1001_0110};

    // Reset state and release
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_pins", {26'd0, ready, busy, cs_n, sck, mosi, done}, 32'b001000);
    rst_n = 1'b1;
    #1 check_output("ready_before_edge", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    check_output("ready_after_edge", {31'd0, ready}, 32'd1);

    // Handshake idle
    bad = 0;
    d0  = done_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (!(ready && !busy && cs_n && !sck)) bad++;
    end
    check_output("idle_hold", bad, 32'd0);
    check_output("idle_no_done", done_cnt - d0, 32'd0);

    // Table-driven single frames (vector 1 changes word_i mid-frame)
    for (int i = 0; i < 3; i++) apply_stimulus(vecs[i], i);

    // Back-to-back with valid held high
    @(negedge clk); #1;
    g0 = gap_cnt; d0 = done_cnt; f0 = busy_rises;
    word  = 24'hFFFFFF;
    valid = 1'b1;
    wait_busy(1'b1, 20, tmo);
    word = 24'h000001;
    check_output("b2b_first_timeout", {31'd0, tmo}, 32'd0);
    tmo = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (busy_rises - f0 >= 2) begin
        tmo = 1'b0;
        break;
      end
    end
    valid = 1'b0;
    check_output("b2b_second_timeout", {31'd0, tmo}, 32'd0);
    wait_busy(1'b0, 400, tmo);
    repeat (2) @(negedge clk);
    #1;
    check_output("b2b_period", busy_rise_cyc - prev_busy_rise_cyc, 32'd201);
    check_output("b2b_last_bit", {31'd0, last_bits[0]}, 32'd1);
    check_output("b2b_bits", last_bits, 32'h000001);
    check_output("b2b_gap_cycles", gap_cnt - g0, 32'd8);
    check_output("b2b_done", done_cnt - d0, 32'd2);

    // Reset in the middle of bit 10 (14th bit sent), during its high phase
    @(negedge clk); #1;
    f0 = frames; d0 = done_cnt;
    word  = 24'hFFFFFF;
    valid = 1'b1;
    wait_busy(1'b1, 20, tmo);
    valid = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rises >= 14) begin
        tmo = 1'b0;
        break;
      end
    end
    check_output("midrst_reach_timeout", {31'd0, tmo}, 32'd0);
    pre = {sck, mosi};
    check_output("midrst_pre_sck_mosi", {30'd0, pre}, 32'b11);
    rst_n = 1'b0;
    #1;
    check_output("midrst_pins", {27'd0, cs_n, sck, mosi, ready, busy}, 32'b10000);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check_output("midrst_ready_low", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    check_output("midrst_ready_high", {31'd0, ready}, 32'd1);
    check_output("midrst_no_done", done_cnt - d0, 32'd0);
    check_output("midrst_no_frame", frames - f0, 32'd0);
    apply_stimulus('{24'h5A5A5A, 1'b0, 24'b0101_1010_0101_1010_0101_1010}, 3);

    // Minimal-timing instance: CLK_DIV=1, all CS times 1, 8-bit word
    @(negedge clk); #1;
    s_word  = 8'h81;
    s_valid = 1'b1;
    @(negedge clk); #1;
    s_valid = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check_output("sweep_bits", {24'd0, s_rx}, 32'b1000_0001);
    check_output("sweep_rises", s_rises, 32'd8);
    check_output("sweep_high_cycles", s_high, 32'd8);
    check_output("sweep_toggles", s_toggles, 32'd16);
    check_output("sweep_busy", s_busy_cnt, 32'd19);
    check_output("sweep_done", s_done_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
